// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: EX operand-mux select codes and shadow tag layout.
package mips_pkg;

    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    localparam int         FWD_SEL_W   = 2;
    localparam logic [1:0] FWD_SEL_REG = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    // Shadow-pipeline destination tag at the default register-file width.
    typedef struct packed {
        logic [DEFAULT_REG_ADDR_WIDTH-1:0] rd;
        logic                              we;
        logic                              ld;
    } tag_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand comparator: forwarding select against EX/MEM tags plus load-use match.
// Purely combinational, no flow control.
module fwd_select
    import mips_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] opnd,
    input  logic                      uses,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_we,
    input  logic                      ex_ld,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      mem_we,
    output logic [1:0]                sel,
    output logic                      ld_hazard
);

    logic ex_hit;
    logic mem_hit;

    // Register 0 is hard-wired, so a write to it never produces forwardable data.
    assign ex_hit  = uses && ex_we  && (ex_rd  != '0) && (ex_rd  == opnd);
    assign mem_hit = uses && mem_we && (mem_rd != '0) && (mem_rd == opnd);

    assign ld_hazard = ex_hit && ex_ld;

    always_comb begin
        sel = FWD_SEL_REG;
        if (ex_hit && !ex_ld)
            sel = FWD_SEL_MEM;
        else if (mem_hit)
            sel = FWD_SEL_WB;
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX forwarding selects (registered, aligned with ID/EX) and combinational load-use stall.
// Optional HAZARD_COUNTERS_EN adds wrapping stall/forward statistics counters.
module forwarding_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_flush,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    input  logic                      i_id_uses_rs,
    input  logic                      i_id_uses_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_regwrite,
    input  logic                      i_id_memread,
    output logic [1:0]                o_cortocircuitoA,
    output logic [1:0]                o_cortocircuitoB,
`ifdef HAZARD_COUNTERS_EN
    output logic [CNT_WIDTH-1:0]      o_stall_count,
    output logic [CNT_WIDTH-1:0]      o_fwd_count,
`endif
    output logic                      o_stall
);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
        logic                      ld;
    } stage_tag_t;

    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;
    stage_tag_t id_tag;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       haz_a;
    logic       haz_b;
    logic       bubble;
    logic       fwd_any;

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_sel_a (
        .opnd      (i_id_rs),
        .uses      (i_id_uses_rs),
        .ex_rd     (ex_tag.rd),
        .ex_we     (ex_tag.we),
        .ex_ld     (ex_tag.ld),
        .mem_rd    (mem_tag.rd),
        .mem_we    (mem_tag.we),
        .sel       (sel_a),
        .ld_hazard (haz_a)
    );

    fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_sel_b (
        .opnd      (i_id_rt),
        .uses      (i_id_uses_rt),
        .ex_rd     (ex_tag.rd),
        .ex_we     (ex_tag.we),
        .ex_ld     (ex_tag.ld),
        .mem_rd    (mem_tag.rd),
        .mem_we    (mem_tag.we),
        .sel       (sel_b),
        .ld_hazard (haz_b)
    );

    // A taken branch kills the ID instruction, so its hazard never stalls.
    assign o_stall = i_enable && !i_flush && (haz_a || haz_b);
    assign bubble  = o_stall || i_flush;
    assign fwd_any = (sel_a != FWD_SEL_REG) || (sel_b != FWD_SEL_REG);

    assign id_tag.rd = i_id_rd;
    assign id_tag.we = i_id_regwrite;
    assign id_tag.ld = i_id_memread;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ex_tag           <= '0;
            mem_tag          <= '0;
            wb_tag           <= '0;
            o_cortocircuitoA <= FWD_SEL_REG;
            o_cortocircuitoB <= FWD_SEL_REG;
        end else if (i_enable) begin
            wb_tag           <= mem_tag;
            mem_tag          <= ex_tag;
            ex_tag           <= bubble ? stage_tag_t'('0) : id_tag;
            o_cortocircuitoA <= bubble ? FWD_SEL_REG : sel_a;
            o_cortocircuitoB <= bubble ? FWD_SEL_REG : sel_b;
        end
    end

`ifdef HAZARD_COUNTERS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stall_count <= '0;
            o_fwd_count   <= '0;
        end else if (i_enable) begin
            if (o_stall)
                o_stall_count <= o_stall_count + CNT_WIDTH'(1);
            if (fwd_any)
                o_fwd_count   <= o_fwd_count + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_fwd_any;
    assign unused_fwd_any = fwd_any;
`endif

    // WB tag is debug-only state; the register file writes early, so it never forwards.
    logic unused_tags;
    assign unused_tags = ^{wb_tag, mem_tag.ld};

endmodule
